fetch_stage: RTL and testbench

//   Instruction-fetch stage of the 32-bit RISC pipeline. Holds the PC and drives the word address into imem.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/if_id_reg.sv | 64 ++++++
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the pipeline stages.
package cpu_pkg;

  typedef logic [31:0] word_t;

  // All-zero word used as the pipeline bubble instruction
  localparam word_t NOP = 32'h0000_0000;

  // Every instruction is one 32-bit word
  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying instruction, its PC and PC+4 between two stages.
// Priority per clock edge: reset > flush (bubble) > stall (hold) > load.
// A bubble clears the instruction and valid bit but keeps the PC fields.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         stall,
  input  logic [n-1:0] instr_in,
  input  logic [n-1:0] pc_in,
  input  logic [n-1:0] pc_plus4_in,
  output logic [n-1:0] instr_out,
  output logic [n-1:0] pc_out,
  output logic [n-1:0] pc_plus4_out,
  output logic         valid_out
);

  logic [n-1:0] instr_q, instr_d;
  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] pc_plus4_q, pc_plus4_d;
  logic         valid_q, valid_d;

  // Choose between bubble, hold and load for the next register contents
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d = n'(NOP);
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end
  end

  // Register the stage contents; synchronous active-low reset gives a bubble
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q    <= n'(NOP);
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_out       = pc_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined;
// otherwise the counter ports read constant zero.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int           n        = 32,
  parameter int           r        = 6,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_f,
  input  logic         flush_d,
  input  logic         redirect_valid,
  input  logic [n-1:0] redirect_target,
  output logic [r-1:0] imem_addr,
  input  logic [n-1:0] imem_readdata,
  output logic [n-1:0] pc_f,
  output logic [n-1:0] instr_d,
  output logic [n-1:0] pc_d,
  output logic [n-1:0] pc_plus4_d,
  output logic         valid_d,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_stall_cnt
);

  localparam logic [n-1:0] RESET_PC_ALIGNED = {RESET_PC[n-1:2], 2'b00};

  logic [n-1:0] pc_q, pc_next;
  logic [n-1:0] pc_plus4;
  logic         squash;
  logic         unused_target_bits;

  assign unused_target_bits = ^redirect_target[1:0];
  assign pc_plus4           = pc_q + n'(INSTR_BYTES);
  assign squash             = flush_d | redirect_valid;

  // Next PC: redirect beats stall, otherwise advance one word
  always_comb begin
    pc_next = pc_plus4;
    if (redirect_valid) begin
      pc_next = {redirect_target[n-1:2], 2'b00};
    end else if (stall_f) begin
      pc_next = pc_q;
    end
  end

  // PC register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC_ALIGNED;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign pc_f      = pc_q;
  assign imem_addr = pc_q[r+1:2];

  if_id_reg #(.n(n)) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .flush        (squash),
    .stall        (stall_f),
    .instr_in     (imem_readdata),
    .pc_in        (pc_q),
    .pc_plus4_in  (pc_plus4),
    .instr_out    (instr_d),
    .pc_out       (pc_d),
    .pc_plus4_out (pc_plus4_d),
    .valid_out    (valid_d)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        fetch_load;

  assign fetch_load = !squash && !stall_f;

  // Count IF/ID loads and stall cycles that are not overridden by a redirect
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_load) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (stall_f && !redirect_valid) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset and wrapping naturally
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard testbench for fetch_stage: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_f = 1'b0;
  logic        flush_d = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_readdata;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  logic [31:0] mem [0:63];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Reference model state: what the fetch stage should hold after each edge
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pcd = 32'h0;
  logic [31:0] m_pc4 = 32'h0;
  logic        m_valid = 1'b0;
  logic [31:0] m_fc = 32'h0;
  logic [31:0] m_sc = 32'h0;

  always #5 clk = ~clk;

  assign imem_readdata = mem[imem_addr];

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_f         (stall_f),
    .flush_d         (flush_d),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_readdata   (imem_readdata),
    .pc_f            (pc_f),
    .instr_d         (instr_d),
    .pc_d            (pc_d),
    .pc_plus4_d      (pc_plus4_d),
    .valid_d         (valid_d),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
  );

  // Advance the model by one clock edge using the architectural fetch rules
  task automatic modelStep(input logic rst, input logic st, input logic fl,
                           input logic rv, input logic [31:0] tgt);
    if (!rst) begin
      m_pc    = 32'h0;
      m_instr = 32'h0;
      m_pcd   = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
      m_fc    = 32'h0;
      m_sc    = 32'h0;
    end else begin
      if (fl || rv) begin
        m_instr = 32'h0;
        m_valid = 1'b0;
      end else if (!st) begin
        m_instr = mem[(m_pc / 4) % 64];
        m_pcd   = m_pc;
        m_pc4   = m_pc + 4;
        m_valid = 1'b1;
        m_fc    = m_fc + 1;
      end
      if (st && !rv) m_sc = m_sc + 1;
      if (rv)       m_pc = (tgt / 4) * 4;
      else if (!st) m_pc = m_pc + 4;
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge
  task automatic applyStimulus(input logic rst, input logic st, input logic fl,
                               input logic rv, input logic [31:0] tgt);
    exp_t e;
    @(posedge clk);
    #2;
    reset           = rst;
    stall_f         = st;
    flush_d         = fl;
    redirect_valid  = rv;
    redirect_target = tgt;
    modelStep(rst, st, fl, rv, tgt);
    e.pc    = m_pc;
    e.instr = m_instr;
    e.pcd   = m_pcd;
    e.pc4   = m_pc4;
    e.valid = m_valid;
`ifdef FETCH_PERF_CNT_EN
    e.fc = m_fc;
    e.sc = m_sc;
`else
    e.fc = 32'h0;
    e.sc = 32'h0;
`endif
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: after every edge, compare the DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("pc_f", pc_f, e.pc);
        checkOutput("imem_addr", {26'h0, imem_addr}, (e.pc / 4) % 64);
        checkOutput("instr_d", instr_d, e.instr);
        checkOutput("pc_d", pc_d, e.pcd);
        checkOutput("pc_plus4_d", pc_plus4_d, e.pc4);
        checkOutput("valid_d", {31'h0, valid_d}, {31'h0, e.valid});
        checkOutput("perf_fetch_cnt", perf_fetch_cnt, e.fc);
        checkOutput("perf_stall_cnt", perf_stall_cnt, e.sc);
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    logic        r_rst, r_st, r_fl, r_rv;
    logic [31:0] r_tgt;

    mem[0] = 32'hA000_0000;
    mem[1] = 32'hA111_1111;
    mem[2] = 32'hA222_2222;
    mem[3] = 32'hA333_3333;
    for (int i = 4; i < 64; i++) mem[i] = $urandom;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("[TB] sequential fetch from reset");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("[TB] three-cycle stall while A1 is in decode");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("[TB] redirect to unaligned target");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0022);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("[TB] stall, flush and redirect together");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("[TB] imem address wrap at 252");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_00FC);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("[TB] PC wrap at 2**32");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("[TB] reset during stall after redirect");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 39) != 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_fl  = ($urandom_range(0, 6) == 0);
      r_rv  = ($urandom_range(0, 6) == 0);
      r_tgt = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      applyStimulus(r_rst, r_st, r_fl, r_rv, r_tgt);
    end

    @(posedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
